wb_ram_slave: RTL and testbench
===============================

Name: wb_ram_slave

Overview:
- Wishbone B3 classic-cycle slave: a word-addressed on-chip RAM with byte-lane writes and a fixed, configurable wait-state count.
- It is the responder end of the CPU's Wishbone master interface, which issues instruction and data accesses that can be stalled or flushed mid-transfer.
- It sits on the bus side of the pipeline and supplies the ack that releases the pipeline stall.

Parameters:
- ADDR_WIDTH, 10: log2 of RAM depth in 32-bit words (1024 words = 4 KiB).
- WAIT_STATES, 1: cycles inserted between sampling a request and asserting ack. Legal range 0..15.
- BASE_ADDR, 32'h0000_0000: byte base address of the window. Aligned to 2^(ADDR_WIDTH+2).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- wb_cyc_i  in  1  bus cycle valid.
- wb_stb_i  in  1  strobe / transfer request.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  32  byte address; bits [1:0] are ignored.
- wb_sel_i  in  4  byte-lane enables; sel[i] covers data bits [8i+7:8i].
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  transfer acknowledge, one-cycle pulse.
- wb_err_o  out  1  error acknowledge, one-cycle pulse (see Optional Feature).

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, wait counter=0.
  - wb_ack_o=0, wb_err_o=0, wb_dat_o=32'h0.
  - RAM contents are NOT cleared.
  - Reset mid-transaction abandons the transfer; no write occurs.
- Address decode:
  - hit = (wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]).
  - word index = wb_adr_i[ADDR_WIDTH+1:2].
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if cyc&stb, latch adr/we/sel/dat_i and hit. Then:
    - WAIT_STATES==0: go to RESP directly.
    - Otherwise: counter=WAIT_STATES-1 and go to WAIT.
  - WAIT:
    - If !(cyc&stb): abort, go to IDLE, no ack, no write.
    - Else if counter==0: go to RESP.
    - Else: decrement counter.
  - RESP: ack (or err) is high for exactly this one cycle; next state is always IDLE.
- Latency: ack is high in cycle N+WAIT_STATES+1, where N is the cycle in which IDLE sampled the request.
  - Minimum turnaround between transfers is one IDLE cycle.
  - A strobe still high during that IDLE cycle starts a new transfer.
- Commit point is the edge entering RESP:
  - Write: RAM bytes whose sel bit is 1 are updated with the latched dat_i; other lanes are untouched.
  - Read: wb_dat_o is loaded with the full 32-bit word; sel is ignored for reads.
  - wb_dat_o holds its value until the next read commit; writes do not change it.
- The latched request is used at commit. Master changes to adr/dat/sel during WAIT are ignored; only cyc/stb are monitored, for abort.
- Out-of-range (hit==0), default build:
  - ack is asserted with normal timing.
  - Reads return 32'h0.
  - Writes are discarded.
- wb_ack_o and wb_err_o are never both 1.

Optional Feature:
- Macro: WB_RAM_ERR_EN.
- Defined: an out-of-range access asserts wb_err_o instead of wb_ack_o, with identical timing. wb_dat_o is unchanged and no write occurs.
- Undefined: wb_err_o is tied to 0 and the default out-of-range behaviour applies.

Decomposition:
- Shared defines file, added alongside the existing ones:
  - WB FSM state encodings (IDLE/WAIT/RESP).
  - WbAddrBus/WbDataBus/WbSelBus width macros.
  - WB_ACK/WB_NOACK constants.
- One sub-module, wb_ram_array:
  - Synchronous single-port memory, depth 2^ADDR_WIDTH.
  - 4 byte-write enables and a registered read port.
  - Instantiated once; the FSM and counter stay in wb_ram_slave.

Test Plan:
- Reset mid-WAIT: rst=0 while in WAIT, WAIT_STATES=3 -> next cycle ack=0, dat_o=0, state IDLE; a subsequent read of that address returns the old data.
- Full write then read, WAIT_STATES=1, adr=0x10, dat=0xDEADBEEF, sel=4'hF -> ack in the 2nd cycle after sampling; read of 0x10 gives dat_o=0xDEADBEEF with ack in the same cycle.
- Byte-lane write: over 0x11223344 at 0x20, write dat=0xAABBCCDD with sel=4'b0101 -> readback 0x11BB33DD.
- Abort during WAIT: WAIT_STATES=3, write 0x55 to 0x30, drop stb after 1 cycle -> no ack ever, readback shows the old value, the next transfer acks normally.
- Zero-wait back-to-back: WAIT_STATES=0, stb held high for 3 reads -> ack pulses on alternating cycles (1,0,1,0,1) with correct data on each.
- Out-of-range: adr=BASE+0x1000 with ADDR_WIDTH=10 -> default build: ack=1, dat_o=0. With WB_RAM_ERR_EN: err=1, ack=0, dat_o unchanged.

Source files
------------

// File: rtl/wb_ram_slave_pkg.sv
// wb_ram_slave_pkg: shared Wishbone widths, handshake constants and FSM state encoding
// Contents: WbAddrBus/WbDataBus/WbSelBus widths, WB_ACK/WB_NOACK levels, wb_state_e (S_IDLE/S_WAIT/S_RESP)
package wb_ram_slave_pkg;
   localparam int WbAddrBus = 32;
   localparam int WbDataBus = 32;
   localparam int WbSelBus  = 4;
   localparam logic WB_ACK   = 1'b1;
   localparam logic WB_NOACK = 1'b0;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} wb_state_e;
endpackage

// File: rtl/wb_ram_slave_if.sv
// wb_ram_slave_if: Wishbone B3 classic bus bundle between a master and the RAM slave
// Signals: wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[31:0], wb_sel_i[3:0], wb_dat_i[31:0] (master -> slave)
//          wb_dat_o[31:0], wb_ack_o, wb_err_o (slave -> master); modports master and slave
interface wb_ram_slave_if;
   import wb_ram_slave_pkg::*;
   logic                 wb_cyc_i;
   logic                 wb_stb_i;
   logic                 wb_we_i;
   logic [WbAddrBus-1:0] wb_adr_i;
   logic [WbSelBus-1:0]  wb_sel_i;
   logic [WbDataBus-1:0] wb_dat_i;
   logic [WbDataBus-1:0] wb_dat_o;
   logic                 wb_ack_o;
   logic                 wb_err_o;
   modport master (output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                   input  wb_dat_o, wb_ack_o, wb_err_o);
   modport slave  (input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
                   output wb_dat_o, wb_ack_o, wb_err_o);
endinterface

// File: rtl/wb_ram_array.sv
// wb_ram_array: single-port 32-bit RAM, depth 2^ADDR_WIDTH, byte write enables, registered read port
// Ports: clk, rst (sync, active-low; clears only the read register), re (load rdata from mem[addr]),
//        clr (load rdata with zero), we[3:0] (byte lanes), addr, wdata, rdata (holds between loads)
module wb_ram_array
   import wb_ram_slave_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  re,
   input  logic                  clr,
   input  logic [WbSelBus-1:0]   we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WbDataBus-1:0]  wdata,
   output logic [WbDataBus-1:0]  rdata
);
   logic [WbDataBus-1:0] mem [2**ADDR_WIDTH];
   always_ff @(posedge clk)
      for (int i = 0; i < WbSelBus; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
   always_ff @(posedge clk)
      if (!rst) rdata <= '0;
      else if (clr) rdata <= '0;
      else if (re) rdata <= mem[addr];
endmodule

// File: rtl/wb_ram_slave.sv
// wb_ram_slave: Wishbone B3 classic slave fronting an on-chip RAM with fixed wait states
// Ports: clk, rst (sync, active-low), bus (wb_ram_slave_if.slave)
// Params: ADDR_WIDTH (log2 words), WAIT_STATES (0..15), BASE_ADDR (window base, size-aligned)
// Build option: define WB_RAM_ERR_EN to answer out-of-window accesses with wb_err_o instead of wb_ack_o
module wb_ram_slave
   import wb_ram_slave_pkg::*;
#(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input logic            clk,
   input logic            rst,
   wb_ram_slave_if.slave  bus
);
   wb_state_e             state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  req, hit, live, commit;
   logic [ADDR_WIDTH-1:0] idx_q, idx_c;
   logic                  we_q, we_c, hit_q, hit_c;
   logic [WbSelBus-1:0]   sel_q, sel_c, ram_we;
   logic [WbDataBus-1:0]  dat_q, dat_c;
   logic                  ram_re, ram_clr;
   logic [1:0]            unused_adr;
   assign req        = bus.wb_cyc_i && bus.wb_stb_i;
   assign hit        = bus.wb_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
   assign unused_adr = bus.wb_adr_i[1:0];
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: if (req) begin
            state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
         end
         S_WAIT: begin
            state_d = !req ? S_IDLE : (cnt_q == 4'd0) ? S_RESP : S_WAIT;
            cnt_d   = (req && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
         end
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk)
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   always_ff @(posedge clk)
      if (state_q == S_IDLE && req) begin
         idx_q <= bus.wb_adr_i[ADDR_WIDTH+1:2];
         we_q  <= bus.wb_we_i;
         sel_q <= bus.wb_sel_i;
         dat_q <= bus.wb_dat_i;
         hit_q <= hit;
      end
   // With zero wait states the commit edge is the sampling edge itself, so the
   // live bus feeds the RAM in IDLE; afterwards only the latched copy is used.
   assign live   = state_q == S_IDLE;
   assign idx_c  = live ? bus.wb_adr_i[ADDR_WIDTH+1:2] : idx_q;
   assign we_c   = live ? bus.wb_we_i : we_q;
   assign sel_c  = live ? bus.wb_sel_i : sel_q;
   assign dat_c  = live ? bus.wb_dat_i : dat_q;
   assign hit_c  = live ? hit : hit_q;
   // Commit on the edge entering RESP; a reset on that edge abandons the transfer.
   assign commit = rst && state_d == S_RESP;
   assign ram_we = (commit && we_c && hit_c) ? sel_c : '0;
   assign ram_re = commit && !we_c && hit_c;
`ifdef WB_RAM_ERR_EN
   assign bus.wb_ack_o = (state_q == S_RESP && hit_q) ? WB_ACK : WB_NOACK;
   assign bus.wb_err_o = state_q == S_RESP && !hit_q;
   assign ram_clr      = 1'b0;
`else
   assign bus.wb_ack_o = (state_q == S_RESP) ? WB_ACK : WB_NOACK;
   assign bus.wb_err_o = 1'b0;
   assign ram_clr      = commit && !we_c && !hit_c;
`endif
   wb_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .re    (ram_re),
      .clr   (ram_clr),
      .we    (ram_we),
      .addr  (idx_c),
      .wdata (dat_c),
      .rdata (bus.wb_dat_o)
   );
endmodule

// File: tb/tb_wb_ram_slave.sv
// tb_wb_ram_slave: directed bench for wb_ram_slave with WAIT_STATES = 0, 1 and 3 instances
module tb_wb_ram_slave;
   localparam int D0 = 0;
   localparam int D1 = 1;
   localparam int D3 = 2;
`ifdef WB_RAM_ERR_EN
   localparam logic [1:0]  OOR_AE = 2'b01;
   localparam logic [31:0] OOR_RD = 32'hDEADBEEF;
`else
   localparam logic [1:0]  OOR_AE = 2'b10;
   localparam logic [31:0] OOR_RD = 32'h0;
`endif
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dat = '0;
   logic [3:0]  sel = '0;
   int          dsel = 0;
   int          tests = 0, fails = 0;
   logic        ack_a [3];
   logic        err_a [3];
   logic [31:0] dat_a [3];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_ram_slave_if bi ();
      assign bi.wb_cyc_i = cyc && dsel == g;
      assign bi.wb_stb_i = stb && dsel == g;
      assign bi.wb_we_i  = we;
      assign bi.wb_adr_i = adr;
      assign bi.wb_sel_i = sel;
      assign bi.wb_dat_i = dat;
      assign ack_a[g]    = bi.wb_ack_o;
      assign err_a[g]    = bi.wb_err_o;
      assign dat_a[g]    = bi.wb_dat_o;
      wb_ram_slave #(.WAIT_STATES(g == 2 ? 3 : g)) dut (.clk(clk), .rst(rst), .bus(bi));
   end

   task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s, output int lat, output logic [31:0] rd, output logic [1:0] ae);
      @(negedge clk);
      dsel = d; we = w; adr = a; dat = wd; sel = s; cyc = 1'b1; stb = 1'b1;
      lat = 0; ae = 2'b00; rd = 'x;
      for (int i = 1; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (ack_a[d] === 1'b1 || err_a[d] === 1'b1) begin
            lat = i; ae = {ack_a[d], err_a[d]}; rd = dat_a[d];
         end
      end
      cyc = 1'b0; stb = 1'b0;
   endtask

   task automatic test_reset;
      for (int k = 0; k < 3; k++) begin
         tests++; if (ack_a[k] !== 1'b0) begin fails++; $display("FAIL reset_ack[%0d]: got %b expected 0", k, ack_a[k]); end
         tests++; if (err_a[k] !== 1'b0) begin fails++; $display("FAIL reset_err[%0d]: got %b expected 0", k, err_a[k]); end
         tests++; if (dat_a[k] !== 32'h0) begin fails++; $display("FAIL reset_dat[%0d]: got %h expected 0", k, dat_a[k]); end
      end
   endtask

   task automatic test_write_read;
      int lat; logic [31:0] rd; logic [1:0] ae;
      xfer(D1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, rd, ae);
      tests++; if (lat != 2 || ae !== 2'b10) begin fails++; $display("FAIL wr_ack: got lat=%0d ack/err=%b expected lat=2 ack/err=10", lat, ae); end
      tests++; if (rd !== 32'h0) begin fails++; $display("FAIL wr_dat_hold: got %h expected 00000000", rd); end
      xfer(D1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (lat != 2 || ae !== 2'b10) begin fails++; $display("FAIL rd_ack: got lat=%0d ack/err=%b expected lat=2 ack/err=10", lat, ae); end
      tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_dat: got %h expected deadbeef", rd); end
   endtask

   task automatic test_byte_lanes;
      int lat; logic [31:0] rd; logic [1:0] ae;
      xfer(D1, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, rd, ae);
      xfer(D1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, rd, ae);
      xfer(D1, 1'b0, 32'h22, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (lat != 2 || rd !== 32'h11BB33DD) begin fails++; $display("FAIL byte_lanes: got lat=%0d dat=%h expected lat=2 dat=11bb33dd", lat, rd); end
   endtask

   task automatic test_latched;
      int lat = 0; logic [31:0] rd; logic [1:0] ae;
      @(negedge clk);
      dsel = D3; we = 1'b1; adr = 32'h50; dat = 32'h01020304; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      adr = 32'h54; dat = 32'hFFFFFFFF; sel = 4'h0;
      for (int i = 2; i <= 40 && lat == 0; i++) begin
         @(negedge clk);
         if (ack_a[D3] === 1'b1) lat = i;
      end
      cyc = 1'b0; stb = 1'b0;
      tests++; if (lat != 4) begin fails++; $display("FAIL latched_ack: got lat=%0d expected 4", lat); end
      xfer(D3, 1'b0, 32'h50, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (lat != 4 || rd !== 32'h01020304) begin fails++; $display("FAIL latched_dat: got lat=%0d dat=%h expected lat=4 dat=01020304", lat, rd); end
   endtask

   task automatic test_abort;
      int lat, acks = 0; logic [31:0] rd; logic [1:0] ae;
      xfer(D3, 1'b1, 32'h30, 32'h77, 4'hF, lat, rd, ae);
      @(negedge clk);
      dsel = D3; we = 1'b1; adr = 32'h30; dat = 32'h55; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack_a[D3] !== 1'b0) acks++;
      end
      tests++; if (acks != 0) begin fails++; $display("FAIL abort_noack: got %0d ack cycles expected 0", acks); end
      xfer(D3, 1'b0, 32'h30, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (lat != 4 || rd !== 32'h77) begin fails++; $display("FAIL abort_dat: got lat=%0d dat=%h expected lat=4 dat=00000077", lat, rd); end
   endtask

   task automatic test_reset_wait;
      int lat; logic [31:0] rd; logic [1:0] ae;
      xfer(D3, 1'b1, 32'h40, 32'h12345678, 4'hF, lat, rd, ae);
      xfer(D3, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL rstw_pre: got %h expected 12345678", rd); end
      @(negedge clk);
      dsel = D3; we = 1'b1; adr = 32'h40; dat = 32'h0BADF00D; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++; if (ack_a[D3] !== 1'b0 || dat_a[D3] !== 32'h0) begin fails++; $display("FAIL rstw_out: got ack=%b dat=%h expected ack=0 dat=00000000", ack_a[D3], dat_a[D3]); end
      rst = 1'b1; cyc = 1'b0; stb = 1'b0;
      xfer(D3, 1'b0, 32'h40, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (lat != 4 || rd !== 32'h12345678) begin fails++; $display("FAIL rstw_old: got lat=%0d dat=%h expected lat=4 dat=12345678", lat, rd); end
   endtask

   task automatic test_back_to_back;
      int lat, n = 0; logic [31:0] rd; logic [1:0] ae; logic [4:0] pat = '0;
      logic [31:0] exp_d [3] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2};
      for (int k = 0; k < 3; k++) xfer(D0, 1'b1, 32'h100 + 32'(4*k), exp_d[k], 4'hF, lat, rd, ae);
      tests++; if (lat != 1 || ae !== 2'b10) begin fails++; $display("FAIL b2b_wr: got lat=%0d ack/err=%b expected lat=1 ack/err=10", lat, ae); end
      @(negedge clk);
      dsel = D0; we = 1'b0; adr = 32'h100; sel = 4'h0; cyc = 1'b1; stb = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         pat = {pat[3:0], ack_a[D0]};
         if (ack_a[D0] === 1'b1 && n < 3) begin
            tests++; if (dat_a[D0] !== exp_d[n]) begin fails++; $display("FAIL b2b_dat[%0d]: got %h expected %h", n, dat_a[D0], exp_d[n]); end
            n++;
            adr = 32'h100 + 32'(4*n);
         end
      end
      cyc = 1'b0; stb = 1'b0;
      tests++; if (pat !== 5'b10101) begin fails++; $display("FAIL b2b_pattern: got %b expected 10101", pat); end
   endtask

   task automatic test_out_of_range;
      int lat; logic [31:0] rd; logic [1:0] ae;
      xfer(D1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_pre: got %h expected deadbeef", rd); end
      xfer(D1, 1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, lat, rd, ae);
      tests++; if (lat != 2 || ae !== OOR_AE || rd !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_wr: got lat=%0d ack/err=%b dat=%h expected lat=2 ack/err=%b dat=deadbeef", lat, ae, rd, OOR_AE); end
      xfer(D1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (lat != 2 || ae !== OOR_AE || rd !== OOR_RD) begin fails++; $display("FAIL oor_rd: got lat=%0d ack/err=%b dat=%h expected lat=2 ack/err=%b dat=%h", lat, ae, rd, OOR_AE, OOR_RD); end
      xfer(D1, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, ae);
      tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL oor_alias: got %h expected deadbeef", rd); end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset;
      rst = 1'b1;
      test_write_read;
      test_byte_lanes;
      test_latched;
      test_abort;
      test_reset_wait;
      test_back_to_back;
      test_out_of_range;
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
